event_capture_snapshot: RTL and testbench
=========================================

// Module: event_capture_snapshot
// PURPOSE
// Front end for the UFM event-save path. It synchronises raw fault/event inputs and detects
// their rising edges. Each asserted event is held in a sticky vector. After a debounce holdoff
// counted in 1 ms ticks, the block freezes a snapshot and requests a UFM save. Feeds the gpi
// input of the UFM read/write engine and consumes that engine's busy/done flags.
// PARAMETERS
// GPI_BIT     512  number of event inputs / snapshot width
// HOLDOFF_MS  10   1 ms ticks accumulated after the first new event before a save request; 0 = no holdoff
// CNT_W       8    width of the saturating save counter
// PORTS
// clk_i         in   1        system clock (on-chip oscillator)
// resetn_i      in   1        asynchronous active-low reset
// tick_1ms_i    in   1        one-clk_i-cycle pulse every 1 ms, from the timer manager
// evt_i         in   GPI_BIT  raw asynchronous event inputs, active high
// clear_i       in   1        1-cycle pulse: clears sticky vector, pend flag, repeat_o and save_cnt_o
// save_busy_i   in   1        UFM engine busy; while high, no new request is issued
// save_done_i   in   1        1-cycle pulse: UFM engine has finished the save
// gpi_o         out  GPI_BIT  frozen snapshot presented to the UFM engine
// save_req_o    out  1        1-cycle save request pulse
// pending_o     out  1        high while FSM != IDLE or pend flag set
// save_cnt_o    out  CNT_W    count of issued save requests, saturates at all-ones
// repeat_o      out  1        sticky: an event re-rose on a bit that was already sticky
// BEHAVIOUR
// - Reset values: all outputs 0, sticky=0, pend=0, sync/edge flops=0, FSM=IDLE, ms counter=0.
// - Input path: 2-flop synchroniser per bit, then a delay flop. new = sync & ~dly.
//   sticky[i] sets on new[i]. evt_i high at clock edge N gives sticky high after edge N+3.
// - A new edge on an already-sticky bit sets repeat_o; sticky is unchanged.
// - clear_i together with new[i] on the same cycle: the set wins for that bit (sticky[i]=1).
// - any_new = |new. It is evaluated every cycle, whatever the FSM state.
// - FSM states:
//   IDLE:      any_new or pend -> HOLDOFF; ms counter=0; pend=0.
//   HOLDOFF:   ms counter increments on tick_1ms_i. Move to REQ on the cycle after the
//              HOLDOFF_MS-th tick (HOLDOFF_MS=0: next cycle). Further events only accumulate.
//              clear_i here -> IDLE.
//   REQ:       wait while save_busy_i=1. When save_busy_i=0: gpi_o<=sticky, save_req_o=1 for
//              one cycle, save_cnt_o+=1 (saturating), -> WAIT_DONE.
//   WAIT_DONE: gpi_o is held stable. any_new sets pend. save_done_i -> IDLE.
//              A save_done_i in any other state is ignored.
// - On returning to IDLE with pend=1, HOLDOFF is re-entered on the next cycle. Deferred events
//   are never lost; they appear in the next snapshot because sticky is cumulative.
// - clear_i in REQ or WAIT_DONE does not abort the request and does not change gpi_o.
// - The snapshot is a full-vector copy with no per-bit masking. gpi_o changes only on REQ exit.
// - Asynchronous reset mid-save drops the request. The downstream engine restarts from its own reset.
// TESTING
// - evt_i[5] 0->1, HOLDOFF_MS=2, ticks every 100 clk -> sticky[5] at +3 clk; save_req_o after 2nd tick; gpi_o[5]=1, save_cnt_o=1.
// - Hold save_busy_i=1 for 50 clk in REQ -> no save_req_o until busy drops; then a single pulse, gpi_o=sticky.
// - evt_i[7] rises in WAIT_DONE, then save_done_i -> pending_o stays 1; 2nd request gpi_o has bits 5 and 7 set; save_cnt_o=2.
// - evt_i[5] pulses low->high again while sticky -> repeat_o=1; clear_i -> repeat_o=0, sticky=0, save_cnt_o=0.
// - clear_i on same cycle as new[9] -> sticky[9]=1. clear_i in HOLDOFF -> IDLE, no save_req_o.
// - CNT_W=2, 5 save cycles -> save_cnt_o saturates at 3. resetn_i low in WAIT_DONE -> all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/event_capture_snapshot.sv
// event_capture_snapshot: synchronises event inputs, keeps a sticky event vector, waits out a ms holdoff, snapshots it and requests a UFM save.
// Ports: clk_i/resetn_i clock and async active-low reset; tick_1ms_i 1 ms strobe; evt_i raw events;
// clear_i clears sticky/pend/repeat/count; save_busy_i/save_done_i UFM engine handshake;
// gpi_o frozen snapshot; save_req_o request pulse; pending_o save in progress or queued;
// save_cnt_o saturating request count; repeat_o event re-rose on an already sticky bit.
module event_capture_snapshot #(
  parameter int GPI_BIT    = 512,
  parameter int HOLDOFF_MS = 10,
  parameter int CNT_W      = 8
) (
  input  logic               clk_i,
  input  logic               resetn_i,
  input  logic               tick_1ms_i,
  input  logic [GPI_BIT-1:0] evt_i,
  input  logic               clear_i,
  input  logic               save_busy_i,
  input  logic               save_done_i,
  output logic [GPI_BIT-1:0] gpi_o,
  output logic               save_req_o,
  output logic               pending_o,
  output logic [CNT_W-1:0]   save_cnt_o,
  output logic               repeat_o
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] HOLDOFF   = 2'd1;
  localparam logic [1:0] REQ       = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;
  localparam int MS_W = HOLDOFF_MS > 1 ? $clog2(HOLDOFF_MS) : 1;
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(HOLDOFF_MS > 0 ? HOLDOFF_MS - 1 : 0);
  logic [GPI_BIT-1:0] sync1_q, sync2_q, dly_q, new_q, sticky_q, sticky_d, gpi_q;
  logic [1:0]         state_q, state_d;
  logic [MS_W-1:0]    ms_q, ms_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d, req_q, rep_q, rep_d;
  logic               any_new, fire, hold_done, set_pend;
  assign any_new   = |new_q;
  assign fire      = state_q == REQ && !save_busy_i;
  assign hold_done = HOLDOFF_MS == 0 || (tick_1ms_i && ms_q == MS_LAST);
  // events landing in WAIT_DONE, or on the cycle the snapshot is taken, miss this snapshot
  assign set_pend  = any_new && (state_q == WAIT_DONE || fire);
  always_comb begin
    state_d = state_q;
    ms_d    = ms_q;
    pend_d  = set_pend || (pend_q && !clear_i);
    case (state_q)
      IDLE: begin
        ms_d = '0;
        if (any_new || (pend_q && !clear_i)) begin
          state_d = HOLDOFF;
          pend_d  = 1'b0;
        end
      end
      HOLDOFF: begin
        state_d = clear_i ? IDLE : hold_done ? REQ : HOLDOFF;
        ms_d    = tick_1ms_i ? ms_q + 1'b1 : ms_q;
      end
      REQ:       state_d = fire ? WAIT_DONE : REQ;
      default:   state_d = save_done_i ? IDLE : WAIT_DONE;
    endcase
  end
  // a new edge beats a simultaneous clear for its own bit
  assign sticky_d = (clear_i ? '0 : sticky_q) | new_q;
  assign rep_d    = !clear_i && (rep_q || |(new_q & sticky_q));
  assign cnt_d    = clear_i ? CNT_W'(fire) : (fire && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      dly_q    <= '0;
      new_q    <= '0;
      sticky_q <= '0;
      gpi_q    <= '0;
      state_q  <= IDLE;
      ms_q     <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      req_q    <= 1'b0;
      rep_q    <= 1'b0;
    end else begin
      sync1_q  <= evt_i;
      sync2_q  <= sync1_q;
      dly_q    <= sync2_q;
      new_q    <= sync2_q & ~dly_q;
      sticky_q <= sticky_d;
      gpi_q    <= fire ? sticky_q : gpi_q;
      state_q  <= state_d;
      ms_q     <= ms_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      req_q    <= fire;
      rep_q    <= rep_d;
    end
  end
  assign gpi_o      = gpi_q;
  assign save_req_o = req_q;
  assign pending_o  = state_q != IDLE || pend_q;
  assign save_cnt_o = cnt_q;
  assign repeat_o   = rep_q;
endmodule

// File: tb/tb_event_capture_snapshot.sv
// tb_event_capture_snapshot: directed table plus hand sequences for event_capture_snapshot.
module tb_event_capture_snapshot;
  typedef struct {
    logic [15:0] evt;
    logic        busy, clr, done, tick;
    int          n;
    logic [15:0] gpi;
    logic        pend;
    logic [1:0]  cnt;
    logic        rep;
    int          reqs;
  } vec_t;
  logic clk = 1'b0, resetn = 1'b0, tick = 1'b0, clr = 1'b0, busy = 1'b0, done = 1'b0;
  logic [15:0] evt = '0;
  logic [15:0] gpi;
  logic        req, pend, rep;
  logic [1:0]  cnt;
  int pass_n = 0, tot_n = 0, req_seen = 0, req_last = 0;
  vec_t tbl[$];
  event_capture_snapshot #(.GPI_BIT(16), .HOLDOFF_MS(2), .CNT_W(2)) dut (
    .clk_i(clk), .resetn_i(resetn), .tick_1ms_i(tick), .evt_i(evt), .clear_i(clr),
    .save_busy_i(busy), .save_done_i(done), .gpi_o(gpi), .save_req_o(req),
    .pending_o(pend), .save_cnt_o(cnt), .repeat_o(rep)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (req) req_seen++;
  task automatic cmp(string nm, int act, int exp);
    tot_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  task automatic chk(string nm, logic [15:0] eg, logic ep, logic [1:0] ec, logic er, int eq);
    cmp({nm, ".gpi"}, int'(gpi), int'(eg));
    cmp({nm, ".pending"}, int'(pend), int'(ep));
    cmp({nm, ".cnt"}, int'(cnt), int'(ec));
    cmp({nm, ".repeat"}, int'(rep), int'(er));
    cmp({nm, ".reqs"}, req_seen - req_last, eq);
    req_last = req_seen;
  endtask
  task automatic run(logic [15:0] e, logic b, logic c, logic d, logic t, int n);
    evt = e; busy = b; clr = c; done = d; tick = t;
    repeat (n) begin
      @(posedge clk); #1;
      clr = 1'b0; done = 1'b0; tick = 1'b0;
    end
    @(negedge clk); #1;
  endtask
  task automatic add(logic [15:0] e, logic b, logic c, logic d, logic t, int n,
                     logic [15:0] g, logic p, logic [1:0] k, logic r, int q);
    vec_t v;
    v.evt = e; v.busy = b; v.clr = c; v.done = d; v.tick = t; v.n = n;
    v.gpi = g; v.pend = p; v.cnt = k; v.rep = r; v.reqs = q;
    tbl.push_back(v);
  endtask
  initial begin
    logic [15:0] ev, gexp, gprev;
    logic [1:0]  ec;
    //   evt      busy clr done tick n    gpi      pend cnt rep reqs
    add(16'h0020, 0, 0, 0, 0,  4, 16'h0000, 1, 0, 0, 0);
    add(16'h0020, 0, 0, 0, 1,  3, 16'h0000, 1, 0, 0, 0);
    add(16'h0020, 1, 0, 0, 1, 50, 16'h0000, 1, 0, 0, 0);
    add(16'h0020, 0, 0, 0, 0,  1, 16'h0020, 1, 1, 0, 1);
    add(16'h0020, 0, 0, 0, 0,  1, 16'h0020, 1, 1, 0, 0);
    add(16'h00A0, 0, 0, 0, 0,  4, 16'h0020, 1, 1, 0, 0);
    add(16'h00A0, 0, 0, 1, 0,  1, 16'h0020, 1, 1, 0, 0);
    add(16'h00A0, 0, 0, 0, 0,  1, 16'h0020, 1, 1, 0, 0);
    add(16'h00A0, 0, 0, 0, 1,  1, 16'h0020, 1, 1, 0, 0);
    add(16'h00A0, 0, 0, 0, 1,  1, 16'h0020, 1, 1, 0, 0);
    add(16'h00A0, 0, 0, 0, 0,  1, 16'h00A0, 1, 2, 0, 1);
    add(16'h00A0, 0, 0, 1, 0,  2, 16'h00A0, 0, 2, 0, 0);
    add(16'h0080, 0, 0, 0, 0,  4, 16'h00A0, 0, 2, 0, 0);
    add(16'h00A0, 0, 0, 0, 0,  4, 16'h00A0, 1, 2, 1, 0);
    add(16'h00A0, 0, 1, 0, 0,  1, 16'h00A0, 0, 0, 0, 0);
    add(16'h00A0, 0, 0, 0, 1,  1, 16'h00A0, 0, 0, 0, 0);
    add(16'h00A0, 0, 0, 0, 1,  3, 16'h00A0, 0, 0, 0, 0);
    add(16'h02A0, 0, 0, 0, 0,  3, 16'h00A0, 0, 0, 0, 0);
    add(16'h02A0, 0, 1, 0, 0,  1, 16'h00A0, 1, 0, 0, 0);
    add(16'h02A0, 0, 0, 0, 1,  1, 16'h00A0, 1, 0, 0, 0);
    add(16'h02A0, 0, 0, 0, 1,  1, 16'h00A0, 1, 0, 0, 0);
    add(16'h02A0, 0, 0, 0, 0,  1, 16'h0200, 1, 1, 0, 1);
    add(16'h02A0, 0, 0, 1, 0,  2, 16'h0200, 0, 1, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset", 16'h0000, 0, 0, 0, 0);
    resetn = 1'b1;
    foreach (tbl[i])
      begin
        run(tbl[i].evt, tbl[i].busy, tbl[i].clr, tbl[i].done, tbl[i].tick, tbl[i].n);
        chk($sformatf("row%0d", i), tbl[i].gpi, tbl[i].pend, tbl[i].cnt, tbl[i].rep, tbl[i].reqs);
      end
    ev = 16'h02A0;
    gexp = 16'h0200;
    ec = 2'd1;
    for (int k = 0; k < 5; k++) begin
      gprev = gexp;
      ev = ev | (16'h0001 << (10 + k));
      run(ev, 0, 0, 0, 0, 4);
      chk($sformatf("sat%0d.hold", k), gprev, 1, ec, 0, 0);
      run(ev, 0, 0, 0, 1, 1);
      run(ev, 0, 0, 0, 1, 1);
      run(ev, 0, 0, 0, 0, 1);
      gexp = gexp | (16'h0001 << (10 + k));
      ec = (ec == 2'd3) ? 2'd3 : ec + 2'd1;
      chk($sformatf("sat%0d.req", k), gexp, 1, ec, 0, 1);
      if (k < 4) begin
        run(ev, 0, 0, 1, 0, 2);
        chk($sformatf("sat%0d.done", k), gexp, 0, ec, 0, 0);
      end
    end
    resetn = 1'b0;
    #1;
    chk("rst_wait", 16'h0000, 0, 0, 0, 0);
    cmp("rst_wait.req", int'(req), 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
